lutram_fifo_ctrl: RTL and testbench
===================================

LUTRAM_FIFO_CTRL -- requirements
Module: lutram_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits (1..64).
REQ-002 The block SHALL have parameter INIT_DATA, default all-zero WIDTH bits, giving the power-up content of every memory word.
REQ-003 Port CLK, input, 1: the only clock; all flops SHALL be rising-edge.
REQ-004 Port RST_N, input, 1: reset, asynchronous, active-low.
REQ-005 Port WR_EN, input, 1: write request.
REQ-006 Port WR_DATA, input, WIDTH: write data.
REQ-007 Port FULL, output, 1: 64 words stored.
REQ-008 Port RD_EN, input, 1: read request.
REQ-009 Port RD_DATA, output, WIDTH: registered read data.
REQ-010 Port RD_VALID, output, 1: RD_DATA holds the word popped on the previous cycle.
REQ-011 Port EMPTY, output, 1: 0 words stored.
REQ-012 Port LEVEL, output, 7: number of stored words, 0..64.

Function
REQ-013 The block SHALL be a 64-deep synchronous FIFO built on dual-port distributed RAM: the write pointer drives the read/write address, and the read pointer drives the read-only address.
REQ-014 Pointers SHALL be 7 bits, with bits [5:0] as the address and bit 6 as the wrap flag; both SHALL wrap 63->0 and toggle bit 6.
REQ-015 A write SHALL be accepted when WR_EN=1 and FULL=0; an accepted write SHALL store WR_DATA at the write-pointer address on that edge and increment the write pointer.
REQ-016 A read SHALL be accepted when RD_EN=1 and EMPTY=0; an accepted read SHALL load RD_DATA from the read-only port on that edge, increment the read pointer and set RD_VALID=1 for exactly the next cycle.
REQ-017 Read latency SHALL be 1 cycle from an accepted RD_EN to RD_DATA/RD_VALID.
REQ-018 RD_DATA SHALL hold its value when no read is accepted.
REQ-019 FULL, EMPTY and LEVEL SHALL be registered and SHALL reflect the state after the current edge.
REQ-020 A write when FULL=1 SHALL be dropped, even if a read is accepted in the same cycle.
REQ-021 A read when EMPTY=1 SHALL be ignored, even if a write is accepted in the same cycle; RD_VALID SHALL stay 0.
REQ-022 When a write and a read are accepted in the same cycle, LEVEL SHALL be unchanged and both pointers SHALL advance.
REQ-023 Status SHALL be derived by these rules: EMPTY when the pointers are fully equal; FULL when the addresses are equal and the wrap bits differ; LEVEL = wr_ptr - rd_ptr modulo 128.

Reset
REQ-024 Asserting RST_N=0 SHALL immediately clear both pointers and set LEVEL=0, EMPTY=1, FULL=0, RD_VALID=0 and RD_DATA=0, including in the middle of any transfer.
REQ-025 Reset SHALL NOT clear the memory contents.
REQ-026 No write SHALL occur while RST_N=0.

Configuration
REQ-027 When LUTFIFO_ERR_FLAGS_EN is defined, the block SHALL add output ports OVERFLOW and UNDERFLOW (1 bit each), reset to 0.
REQ-028 With LUTFIFO_ERR_FLAGS_EN defined, OVERFLOW SHALL set sticky on any dropped write, UNDERFLOW SHALL set sticky on any ignored read, and both SHALL clear only on reset.
REQ-029 When LUTFIFO_ERR_FLAGS_EN is not defined, those ports and their logic SHALL be absent.

Structure
REQ-030 A shared package lutram_fifo_pkg SHALL hold the constants FIFO_DEPTH=64, PTR_W=7 and ADDR_W=6.
REQ-031 Storage SHALL be WIDTH generate-instantiated RAM64X1D cells, one per data bit, with IS_WCLK_INVERTED=0 and INIT taken from the matching INIT_DATA bit; no other sub-module SHALL be used.

Verification
REQ-032 The bench SHALL cover: after reset, write 0xA5 then assert RD_EN -> the next cycle shows RD_DATA=0xA5 and RD_VALID=1, with EMPTY=1 and LEVEL=0 after that read.
REQ-033 The bench SHALL cover: 64 writes of 0..63 -> FULL=1 and LEVEL=64; a 65th write of 0xFF is dropped (OVERFLOW=1 if enabled); 64 reads return 0..63 in order.
REQ-034 The bench SHALL cover: RD_EN with EMPTY=1 -> RD_VALID=0, RD_DATA unchanged and pointers unchanged (UNDERFLOW=1 if enabled).
REQ-035 The bench SHALL cover: hold LEVEL=32, then 200 cycles of simultaneous write+read -> LEVEL stays 32, pointers wrap 63->0 at least twice, and data order is preserved.
REQ-036 The bench SHALL cover: with FULL=1, simultaneous WR_EN+RD_EN -> the read is accepted, the write is dropped, the next cycle shows LEVEL=63 and FULL=0.
REQ-037 The bench SHALL cover: RST_N low mid-stream with LEVEL=10 -> immediately EMPTY=1, LEVEL=0 and RD_VALID=0; after release, a write of 0x3C is read back correctly.

Source files
------------

// File: rtl/lutram_fifo_pkg.sv
// Shared constants and status helpers for the 64-deep distributed-RAM FIFO.
// Contents:
//   FIFO_DEPTH : number of storage words
//   PTR_W      : pointer width (address + wrap flag)
//   ADDR_W     : RAM address width
//   PTR_ONE    : pointer increment constant
//   ptr_full() : full test on a pair of pointers
//   ptr_empty(): empty test on a pair of pointers
package lutram_fifo_pkg;

  localparam int FIFO_DEPTH = 64;
  localparam int PTR_W      = 7;
  localparam int ADDR_W     = 6;

  localparam logic [PTR_W-1:0] PTR_ONE = 7'd1;

  // Full: same RAM address, but the writer is one lap ahead of the reader.
  function automatic logic ptr_full(input logic [PTR_W-1:0] wp,
                                    input logic [PTR_W-1:0] rp);
    return (wp[ADDR_W-1:0] == rp[ADDR_W-1:0]) && (wp[PTR_W-1] != rp[PTR_W-1]);
  endfunction

  // Empty: pointers identical, including the wrap flag.
  function automatic logic ptr_empty(input logic [PTR_W-1:0] wp,
                                     input logic [PTR_W-1:0] rp);
    return (wp == rp);
  endfunction

endpackage

// File: rtl/RAM64X1D.sv
// Behavioural model of the 64x1 dual-port distributed RAM cell.
// Ports:
//   WCLK        : write clock (polarity selected by IS_WCLK_INVERTED)
//   WE, D       : write enable and write data bit
//   A0..A5      : read/write address; SPO is the asynchronous read at A
//   DPRA0..DPRA5: read-only address; DPO is the asynchronous read at DPRA
// Parameters:
//   INIT             : power-up content, bit n = word n
//   IS_WCLK_INVERTED : 1 = write on the falling edge of WCLK
module RAM64X1D #(
  parameter logic [63:0] INIT             = 64'h0,
  parameter logic        IS_WCLK_INVERTED = 1'b0
) (
  output logic SPO,
  output logic DPO,
  input  logic D,
  input  logic WCLK,
  input  logic WE,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic A4,
  input  logic A5,
  input  logic DPRA0,
  input  logic DPRA1,
  input  logic DPRA2,
  input  logic DPRA3,
  input  logic DPRA4,
  input  logic DPRA5
);

  logic [63:0] mem_r = INIT;
  logic [5:0]  a_s;
  logic [5:0]  dpra_s;
  logic        wclk_s;

  assign a_s    = {A5, A4, A3, A2, A1, A0};
  assign dpra_s = {DPRA5, DPRA4, DPRA3, DPRA2, DPRA1, DPRA0};
  assign wclk_s = WCLK ^ IS_WCLK_INVERTED;
  assign SPO    = mem_r[a_s];
  assign DPO    = mem_r[dpra_s];

  // Synchronous single-bit write at the read/write address.
  always_ff @(posedge wclk_s) begin
    if (WE) begin
      mem_r[a_s] <= D;
    end
  end

endmodule

// File: rtl/lutram_fifo_ctrl.sv
// 64-deep synchronous FIFO on dual-port distributed RAM.
// The write pointer drives the RAM read/write address, the read pointer the
// read-only address; RD_DATA is registered from the read-only port.
// Ports:
//   CLK, RST_N         : rising-edge clock, asynchronous active-low reset
//   WR_EN, WR_DATA     : write request and data (dropped when FULL)
//   RD_EN              : read request (ignored when EMPTY)
//   RD_DATA, RD_VALID  : popped word, valid for the cycle after the read
//   FULL, EMPTY, LEVEL : registered status after the current edge
//   OVERFLOW/UNDERFLOW : sticky error flags, only with LUTFIFO_ERR_FLAGS_EN
// Build option: define LUTFIFO_ERR_FLAGS_EN to add the error flag ports.
module lutram_fifo_ctrl
  import lutram_fifo_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] INIT_DATA = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             WR_EN,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic             FULL,
  input  logic             RD_EN,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             RD_VALID,
  output logic             EMPTY,
  output logic [6:0]       LEVEL
`ifdef LUTFIFO_ERR_FLAGS_EN
  ,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
`endif
);

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_nxt_s;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic             wr_acc_s;
  logic             rd_acc_s;
  logic             ram_we_s;
  logic [WIDTH-1:0] dpo_s;
  logic [WIDTH-1:0] spo_unused;

  // Accept/next-pointer logic; the RAM write strobe is also gated by reset
  // because FULL reads 0 while reset is held.
  always_comb begin
    wr_acc_s     = WR_EN & ~FULL;
    rd_acc_s     = RD_EN & ~EMPTY;
    ram_we_s     = wr_acc_s & RST_N;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (wr_acc_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (rd_acc_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
  end

  // One RAM cell per data bit; every word powers up to INIT_DATA.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    RAM64X1D #(
      .INIT             ({64{INIT_DATA[b]}}),
      .IS_WCLK_INVERTED (1'b0)
    ) u_ram (
      .SPO   (spo_unused[b]),
      .DPO   (dpo_s[b]),
      .D     (WR_DATA[b]),
      .WCLK  (CLK),
      .WE    (ram_we_s),
      .A0    (wr_ptr_r[0]),
      .A1    (wr_ptr_r[1]),
      .A2    (wr_ptr_r[2]),
      .A3    (wr_ptr_r[3]),
      .A4    (wr_ptr_r[4]),
      .A5    (wr_ptr_r[5]),
      .DPRA0 (rd_ptr_r[0]),
      .DPRA1 (rd_ptr_r[1]),
      .DPRA2 (rd_ptr_r[2]),
      .DPRA3 (rd_ptr_r[3]),
      .DPRA4 (rd_ptr_r[4]),
      .DPRA5 (rd_ptr_r[5])
    );
  end

  // Pointers, status derived from the next pointers, and registered read port.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_r <= 7'd0;
      rd_ptr_r <= 7'd0;
      EMPTY    <= 1'b1;
      FULL     <= 1'b0;
      LEVEL    <= 7'd0;
      RD_VALID <= 1'b0;
      RD_DATA  <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      EMPTY    <= ptr_empty(wr_ptr_nxt_s, rd_ptr_nxt_s);
      FULL     <= ptr_full(wr_ptr_nxt_s, rd_ptr_nxt_s);
      LEVEL    <= wr_ptr_nxt_s - rd_ptr_nxt_s;
      RD_VALID <= rd_acc_s;
      if (rd_acc_s) begin
        RD_DATA <= dpo_s;
      end else begin
        RD_DATA <= RD_DATA;
      end
    end
  end

`ifdef LUTFIFO_ERR_FLAGS_EN
  // Sticky error flags: set on a dropped write / ignored read, cleared by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (WR_EN & FULL) begin
        OVERFLOW <= 1'b1;
      end
      if (RD_EN & EMPTY) begin
        UNDERFLOW <= 1'b1;
      end
    end
  end
`else
  // Error flags are not built in this configuration.
`endif

endmodule

// File: tb/tb_lutram_fifo_ctrl.sv
// Scoreboard bench for lutram_fifo_ctrl: stimulus pushes expected read data
// into exp_q, a negedge monitor pops and compares whenever a read is due.
module tb_lutram_fifo_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       WR_EN;
  logic [7:0] WR_DATA;
  logic       FULL;
  logic       RD_EN;
  logic [7:0] RD_DATA;
  logic       RD_VALID;
  logic       EMPTY;
  logic [6:0] LEVEL;
`ifdef LUTFIFO_ERR_FLAGS_EN
  logic       OVERFLOW;
  logic       UNDERFLOW;
`endif

  int checks = 0;
  int fails  = 0;

  logic [7:0] mdl_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_rd;
  logic [6:0] mdl_wp;
  logic [6:0] mdl_rp;
  logic       mdl_ovf;
  logic       mdl_udf;

  lutram_fifo_ctrl #(.WIDTH(8), .INIT_DATA(8'h00)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .WR_EN    (WR_EN),
    .WR_DATA  (WR_DATA),
    .FULL     (FULL),
    .RD_EN    (RD_EN),
    .RD_DATA  (RD_DATA),
    .RD_VALID (RD_VALID),
    .EMPTY    (EMPTY),
    .LEVEL    (LEVEL)
`ifdef LUTFIFO_ERR_FLAGS_EN
    ,
    .OVERFLOW (OVERFLOW),
    .UNDERFLOW(UNDERFLOW)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mdl_q.delete();
    exp_q.delete();
    last_rd = 8'h00;
    mdl_wp  = 7'd0;
    mdl_rp  = 7'd0;
    mdl_ovf = 1'b0;
    mdl_udf = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_level"}, 32'(LEVEL), 32'(mdl_q.size()));
    chk({tag, "_empty"}, 32'(EMPTY), 32'(mdl_q.size() == 0));
    chk({tag, "_full"}, 32'(FULL), 32'(mdl_q.size() == 64));
    chk({tag, "_rd_data_hold"}, 32'(RD_DATA), 32'(last_rd));
    chk({tag, "_wr_ptr"}, 32'(dut.wr_ptr_r), 32'(mdl_wp));
    chk({tag, "_rd_ptr"}, 32'(dut.rd_ptr_r), 32'(mdl_rp));
`ifdef LUTFIFO_ERR_FLAGS_EN
    chk({tag, "_overflow"}, 32'(OVERFLOW), 32'(mdl_ovf));
    chk({tag, "_underflow"}, 32'(UNDERFLOW), 32'(mdl_udf));
`endif
  endtask

  // One clock of stimulus; called at a negedge, returns at the next negedge.
  task automatic step(input logic wr, input logic [7:0] wd, input logic rd, input string tag);
    logic wacc;
    logic racc;
    wacc    = wr && (mdl_q.size() < 64);
    racc    = rd && (mdl_q.size() > 0);
    WR_EN   = wr;
    WR_DATA = wd;
    RD_EN   = rd;
    @(posedge CLK);
    if (wr && !wacc) mdl_ovf = 1'b1;
    if (rd && !racc) mdl_udf = 1'b1;
    if (racc) begin
      last_rd = mdl_q.pop_front();
      exp_q.push_back(last_rd);
      mdl_rp = mdl_rp + 7'd1;
    end
    if (wacc) begin
      mdl_q.push_back(wd);
      mdl_wp = mdl_wp + 7'd1;
    end
    @(negedge CLK);
    WR_EN = 1'b0;
    RD_EN = 1'b0;
    check_status(tag);
  endtask

  // Monitor: a read accepted on the last edge must show up at this negedge.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mon_rd_valid", 32'(RD_VALID), 32'd1);
        chk("mon_rd_data", 32'(RD_DATA), 32'(e));
      end else begin
        chk("mon_rd_valid_idle", 32'(RD_VALID), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N   = 1'b0;
    WR_EN   = 1'b0;
    WR_DATA = 8'h00;
    RD_EN   = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    chk("rst_empty", 32'(EMPTY), 32'd1);
    chk("rst_full", 32'(FULL), 32'd0);
    chk("rst_level", 32'(LEVEL), 32'd0);
    chk("rst_rd_valid", 32'(RD_VALID), 32'd0);
    chk("rst_rd_data", 32'(RD_DATA), 32'd0);
    RST_N = 1'b1;

    // Single word through: 0xA5, one-cycle read latency.
    step(1'b1, 8'hA5, 1'b0, "a5_wr");
    chk("a5_level_1", 32'(LEVEL), 32'd1);
    step(1'b0, 8'h00, 1'b1, "a5_rd");
    chk("a5_rd_data", 32'(RD_DATA), 32'hA5);
    chk("a5_empty", 32'(EMPTY), 32'd1);
    chk("a5_level_0", 32'(LEVEL), 32'd0);

    // Read while empty: ignored, RD_DATA holds 0xA5.
    step(1'b0, 8'h00, 1'b1, "udf");
    chk("udf_rd_data", 32'(RD_DATA), 32'hA5);
    chk("udf_rd_ptr", 32'(dut.rd_ptr_r), 32'd1);

    // Fill to 64, 65th write dropped, drain in order.
    for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b0, "fill");
    chk("fill_full", 32'(FULL), 32'd1);
    chk("fill_level", 32'(LEVEL), 32'd64);
    step(1'b1, 8'hFF, 1'b0, "ovf");
    chk("ovf_level", 32'(LEVEL), 32'd64);
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 8'h00, 1'b1, "drain");
      chk("drain_value", 32'(RD_DATA), 32'(i));
    end
    chk("drain_empty", 32'(EMPTY), 32'd1);

    // Refill, then write+read while full: read wins, write dropped.
    for (int i = 0; i < 64; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, "refill");
    chk("refill_full", 32'(FULL), 32'd1);
    step(1'b1, 8'hEE, 1'b1, "full_wr_rd");
    chk("full_wr_rd_level", 32'(LEVEL), 32'd63);
    chk("full_wr_rd_full", 32'(FULL), 32'd0);
    chk("full_wr_rd_data", 32'(RD_DATA), 32'h40);

    // Bring level to 32, then 200 cycles of simultaneous write+read.
    for (int i = 0; i < 31; i++) step(1'b0, 8'h00, 1'b1, "to32");
    chk("to32_level", 32'(LEVEL), 32'd32);
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 8'(i) ^ 8'h5A, 1'b1, "stream");
      chk("stream_level", 32'(LEVEL), 32'd32);
    end
    chk("stream_wr_ptr", 32'(dut.wr_ptr_r), 32'd73);
    chk("stream_rd_ptr", 32'(dut.rd_ptr_r), 32'd41);

    // Drain to level 10, the last step being a read, then reset mid-stream.
    for (int i = 0; i < 22; i++) step(1'b0, 8'h00, 1'b1, "to10");
    chk("to10_level", 32'(LEVEL), 32'd10);
    #2;
    RST_N = 1'b0;
    #1;
    chk("midrst_empty", 32'(EMPTY), 32'd1);
    chk("midrst_level", 32'(LEVEL), 32'd0);
    chk("midrst_rd_valid", 32'(RD_VALID), 32'd0);
    chk("midrst_full", 32'(FULL), 32'd0);
    chk("midrst_rd_data", 32'(RD_DATA), 32'd0);
    model_reset();
    WR_EN   = 1'b1;
    WR_DATA = 8'h99;
    @(negedge CLK);
    WR_EN = 1'b0;
    check_status("in_rst");
    RST_N = 1'b1;
    step(1'b1, 8'h3C, 1'b0, "post_rst_wr");
    step(1'b0, 8'h00, 1'b1, "post_rst_rd");
    chk("post_rst_rd_data", 32'(RD_DATA), 32'h3C);
    chk("post_rst_empty", 32'(EMPTY), 32'd1);

    step(1'b0, 8'h00, 1'b0, "idle");
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
